// File: rtl/lbp_pkg.sv
// Shared types, constants and the LBP code function
// for the streaming LBP engine.
package lbp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    BORDER,
    DONE
  } state_e;

  localparam int LBP_MAXDW = 16;
  localparam int LBP_NB    = 8;

  // Window slots are raster ordered 0..8 with the centre in slot 4.
  localparam logic [3:0] LBP_CTR = 4'd4;
  localparam logic [3:0] LBP_POS [LBP_NB] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8
  };
  localparam logic [7:0] LBP_WEIGHT [LBP_NB] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
  };

  typedef logic [8:0][LBP_MAXDW-1:0] lbp_win_t;

  function automatic logic [7:0] lbp_code(
    input lbp_win_t             win,
    input logic [LBP_MAXDW-1:0] t
  );
    logic [LBP_MAXDW:0] ref_v;
    logic [7:0]         code;
    ref_v = {1'b0, win[LBP_CTR]} + {1'b0, t};
    code  = '0;
    for (int p = 0; p < LBP_NB; p++) begin
      if ({1'b0, win[LBP_POS[p]]} >= ref_v)
        code = code | LBP_WEIGHT[p];
    end
    return code;
  endfunction

endpackage

// File: rtl/lbp_stream_engine_line_buf.sv
// Two-row line buffer: rows r-2 and r-1 at column col,
// shifted up by one row on every accepted pixel.
module lbp_line_buf #(
  parameter int WIDTH = 128,
  parameter int DW    = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [CW-1:0] col,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] row2,
  output logic [DW-1:0] row1
);

  logic [DW-1:0] buf0_q [WIDTH];
  logic [DW-1:0] buf1_q [WIDTH];

  assign row2 = buf0_q[col];
  assign row1 = buf1_q[col];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else if (we) begin
      buf0_q[col] <= buf1_q[col];
      buf1_q[col] <= din;
    end
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Raster-streaming LBP engine: one read per pixel,
// one code per interior pixel, optional border zero-fill.
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int DW           = 8,
  parameter int AW           = $clog2(WIDTH*HEIGHT),
  parameter bit BORDER_WRITE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  input  logic [DW-1:0] cfg_thresh,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [AW-1:0] NB_A =
    AW'(2*WIDTH + 2*(HEIGHT-2));

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] thr_q, thr_d;
  logic [DW-1:0] wt_q [2], wt_d [2];
  logic [DW-1:0] wm_q [2], wm_d [2];
  logic [DW-1:0] wb_q [2], wb_d [2];
  logic          val_q, val_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic [7:0]    ldata_q, ldata_d;
  logic          fin_q, fin_d;
  logic [AW-1:0] bidx_q, bidx_d;
  logic [AW-1:0] baddr_q, baddr_d;

  logic [DW-1:0] row2, row1;
  logic [AW-1:0] bnext;
  logic          bload;
  lbp_win_t      win;

  assign gray_req  = (state_q == READ) && gray_ready;
  assign gray_addr = raddr_q;
  assign lbp_valid = val_q;
  assign lbp_addr  = laddr_q;
  assign lbp_data  = ldata_q;
  assign finish    = fin_q;

  lbp_line_buf #(
    .WIDTH(WIDTH),
    .DW   (DW),
    .CW   (CW)
  ) u_line_buf (
    .clk  (clk),
    .reset(reset),
    .we   (gray_req),
    .col  (col_q),
    .din  (gray_data),
    .row2 (row2),
    .row1 (row1)
  );

  // Border walk: row 0, row H-1, then col 0 / col W-1 pairs.
  always_comb begin
    bnext = baddr_q + AW'(1);
    if (bidx_q == AW'(WIDTH-1))
      bnext = AW'((HEIGHT-1)*WIDTH);
    else if (bidx_q == AW'(2*WIDTH-1))
      bnext = AW'(WIDTH);
    else if (bidx_q > AW'(2*WIDTH-1) && !bidx_q[0])
      bnext = baddr_q + AW'(WIDTH-1);
  end

  always_comb begin
    win[0] = LBP_MAXDW'(wt_q[0]);
    win[1] = LBP_MAXDW'(wt_q[1]);
    win[2] = LBP_MAXDW'(row2);
    win[3] = LBP_MAXDW'(wm_q[0]);
    win[4] = LBP_MAXDW'(wm_q[1]);
    win[5] = LBP_MAXDW'(row1);
    win[6] = LBP_MAXDW'(wb_q[0]);
    win[7] = LBP_MAXDW'(wb_q[1]);
    win[8] = LBP_MAXDW'(gray_data);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    raddr_d = raddr_q;
    thr_d   = thr_q;
    wt_d    = wt_q;
    wm_d    = wm_q;
    wb_d    = wb_q;
    val_d   = 1'b0;
    laddr_d = laddr_q;
    ldata_d = ldata_q;
    bidx_d  = bidx_q;
    baddr_d = baddr_q;
    bload   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gray_ready) begin
          state_d = READ;
          thr_d   = cfg_thresh;
        end
      end
      READ: begin
        if (gray_req) begin
          wt_d[0] = wt_q[1];
          wt_d[1] = row2;
          wm_d[0] = wm_q[1];
          wm_d[1] = row1;
          wb_d[0] = wb_q[1];
          wb_d[1] = gray_data;
          raddr_d = raddr_q + AW'(1);
          if (col_q == CW'(WIDTH-1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            val_d   = 1'b1;
            laddr_d = raddr_q - AW'(WIDTH+1);
            ldata_d = lbp_code(win, LBP_MAXDW'(thr_q));
          end
          if (row_q == RW'(HEIGHT-1) &&
              col_q == CW'(WIDTH-1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = BORDER_WRITE ? BORDER : DONE;
        bload   = BORDER_WRITE;
      end
      BORDER: begin
        if (bidx_q == NB_A) state_d = DONE;
        else                bload   = 1'b1;
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (bload) begin
      val_d   = 1'b1;
      laddr_d = baddr_q;
      ldata_d = 8'h00;
      bidx_d  = bidx_q + AW'(1);
      baddr_d = bnext;
    end

    fin_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      raddr_q <= '0;
      thr_q   <= '0;
      wt_q    <= '{default: '0};
      wm_q    <= '{default: '0};
      wb_q    <= '{default: '0};
      val_q   <= 1'b0;
      laddr_q <= '0;
      ldata_q <= '0;
      fin_q   <= 1'b0;
      bidx_q  <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      raddr_q <= raddr_d;
      thr_q   <= thr_d;
      wt_q    <= wt_d;
      wm_q    <= wm_d;
      wb_q    <= wb_d;
      val_q   <= val_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
      fin_q   <= fin_d;
      bidx_q  <= bidx_d;
      baddr_q <= baddr_d;
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench for lbp_stream_engine: three small
// instances (4x4, 5x4, 4x4 with border fill).
module tb_lbp_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n, rdy, req, val, fin;
  logic [7:0] thr  [3];
  logic [7:0] gdat [3];
  logic [7:0] ldat [3];
  logic [3:0] ga_a, la_a, ga_c, la_c;
  logic [4:0] ga_b, la_b;
  int ga [3];
  int la [3];

  logic [7:0] img  [3][20];
  logic [7:0] mem  [3][20];
  logic [7:0] fill [3];
  int wid [3];
  int rcnt [3], wcnt [3], both [3];
  int cyc [3], lastw [3], frise [3];
  int ord [3][24];

  int nvec = 0;
  int nbad = 0;

  assign ga[0] = 32'(ga_a);
  assign ga[1] = 32'(ga_b);
  assign ga[2] = 32'(ga_c);
  assign la[0] = 32'(la_a);
  assign la[1] = 32'(la_b);
  assign la[2] = 32'(la_c);
  assign gdat[0] = img[0][ga_a];
  assign gdat[1] = img[1][ga_b];
  assign gdat[2] = img[2][ga_c];

  lbp_stream_engine #(
    .WIDTH(4), .HEIGHT(4), .DW(8), .AW(4),
    .BORDER_WRITE(1'b0)
  ) u_a (
    .clk(clk), .reset(rst_n[0]),
    .gray_ready(rdy[0]), .gray_req(req[0]),
    .gray_addr(ga_a), .gray_data(gdat[0]),
    .cfg_thresh(thr[0]), .lbp_valid(val[0]),
    .lbp_addr(la_a), .lbp_data(ldat[0]),
    .finish(fin[0])
  );

  lbp_stream_engine #(
    .WIDTH(5), .HEIGHT(4), .DW(8), .AW(5),
    .BORDER_WRITE(1'b0)
  ) u_b (
    .clk(clk), .reset(rst_n[1]),
    .gray_ready(rdy[1]), .gray_req(req[1]),
    .gray_addr(ga_b), .gray_data(gdat[1]),
    .cfg_thresh(thr[1]), .lbp_valid(val[1]),
    .lbp_addr(la_b), .lbp_data(ldat[1]),
    .finish(fin[1])
  );

  lbp_stream_engine #(
    .WIDTH(4), .HEIGHT(4), .DW(8), .AW(4),
    .BORDER_WRITE(1'b1)
  ) u_c (
    .clk(clk), .reset(rst_n[2]),
    .gray_ready(rdy[2]), .gray_req(req[2]),
    .gray_addr(ga_c), .gray_data(gdat[2]),
    .cfg_thresh(thr[2]), .lbp_valid(val[2]),
    .lbp_addr(la_c), .lbp_data(ldat[2]),
    .finish(fin[2])
  );

  // LBP memory model plus bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!rst_n[u]) begin
        rcnt[u] = 0; wcnt[u] = 0; both[u] = 0;
        cyc[u] = 0; lastw[u] = -1; frise[u] = -1;
        for (int a = 0; a < 20; a++) mem[u][a] = fill[u];
      end else begin
        cyc[u]++;
        if (req[u]) rcnt[u]++;
        if (val[u]) begin
          if (la[u] < 20) mem[u][la[u]] = ldat[u];
          if (wcnt[u] < 24) ord[u][wcnt[u]] = la[u];
          lastw[u] = cyc[u];
          wcnt[u]++;
        end
        if (val[u] && fin[u]) both[u]++;
        if (fin[u] && frise[u] < 0) frise[u] = cyc[u];
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic load_img(input int u, input int pat);
    for (int a = 0; a < 20; a++) begin
      case (pat)
        0:       img[u][a] = 8'h50;
        1:       img[u][a] = 8'(a % wid[u]);
        default: img[u][a] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic start(input int u, input logic [7:0] t);
    rst_n[u] = 1'b0;
    rdy[u]   = 1'b0;
    thr[u]   = t;
    #1;
    check($sformatf("u%0d reset ctl", u),
          {29'd0, req[u], val[u], fin[u]}, 32'd0);
    check($sformatf("u%0d reset addr", u),
          ga[u] + la[u] + 32'(ldat[u]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[u] = 1'b1;
    rdy[u]   = 1'b1;
  endtask

  task automatic wait_fin(input int u);
    int n;
    n = 0;
    while (!fin[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d finish seen", u),
          32'(fin[u]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic job_checks(input int u);
    int exp_w;
    exp_w = (wid[u] - 2) * 2 + ((u == 2) ? 12 : 0);
    check($sformatf("u%0d reads", u), rcnt[u], wid[u] * 4);
    check($sformatf("u%0d writes", u), wcnt[u], exp_w);
    check($sformatf("u%0d valid&finish", u), both[u], 0);
    check($sformatf("u%0d finish timing", u),
          frise[u], lastw[u] + 1);
  endtask

  function automatic logic [7:0] ref_b(input int r,
                                       input int c,
                                       input int t);
    int gc, k;
    logic [7:0] code;
    gc   = int'(img[1][r*5+c]);
    code = 8'h00;
    k    = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) begin
          if (int'(img[1][(r+dr)*5+c+dc]) >= gc + t)
            code[k] = 1'b1;
          k++;
        end
    return code;
  endfunction

  task automatic check_b(input string nm);
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 3; c++)
        check($sformatf("%s r%0dc%0d", nm, r, c),
              32'(mem[1][r*5+c]), 32'(ref_b(r, c, 3)));
  endtask

  typedef struct {
    int         u;
    int         pat;
    logic [7:0] t;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [26];
  int   exp_ord [16];

  initial begin
    int cu, cp, n;
    logic [7:0] ct;

    rst_n = '0;
    rdy   = '0;
    thr   = '{8'h00, 8'h00, 8'h00};
    fill  = '{8'h33, 8'h5A, 8'hAA};
    wid   = '{4, 5, 4};

    vt[0]  = '{0, 0, 8'd0, 5,  8'hFF};
    vt[1]  = '{0, 0, 8'd0, 6,  8'hFF};
    vt[2]  = '{0, 0, 8'd0, 9,  8'hFF};
    vt[3]  = '{0, 0, 8'd0, 10, 8'hFF};
    vt[4]  = '{0, 0, 8'd0, 0,  8'h33};
    vt[5]  = '{0, 0, 8'd0, 15, 8'h33};
    vt[6]  = '{0, 0, 8'd1, 5,  8'h00};
    vt[7]  = '{0, 0, 8'd1, 6,  8'h00};
    vt[8]  = '{0, 0, 8'd1, 9,  8'h00};
    vt[9]  = '{0, 0, 8'd1, 10, 8'h00};
    vt[10] = '{0, 0, 8'd1, 3,  8'h33};
    vt[11] = '{1, 1, 8'd0, 6,  8'hD6};
    vt[12] = '{1, 1, 8'd0, 7,  8'hD6};
    vt[13] = '{1, 1, 8'd0, 8,  8'hD6};
    vt[14] = '{1, 1, 8'd0, 11, 8'hD6};
    vt[15] = '{1, 1, 8'd0, 12, 8'hD6};
    vt[16] = '{1, 1, 8'd0, 13, 8'hD6};
    vt[17] = '{1, 1, 8'd0, 5,  8'h5A};
    vt[18] = '{2, 0, 8'd0, 0,  8'h00};
    vt[19] = '{2, 0, 8'd0, 3,  8'h00};
    vt[20] = '{2, 0, 8'd0, 12, 8'h00};
    vt[21] = '{2, 0, 8'd0, 15, 8'h00};
    vt[22] = '{2, 0, 8'd0, 4,  8'h00};
    vt[23] = '{2, 0, 8'd0, 11, 8'h00};
    vt[24] = '{2, 0, 8'd0, 5,  8'hFF};
    vt[25] = '{2, 0, 8'd0, 10, 8'hFF};
    exp_ord = '{5, 6, 9, 10, 0, 1, 2, 3,
                12, 13, 14, 15, 4, 7, 8, 11};

    repeat (2) @(posedge clk);
    #1;

    cu = -1; cp = -1; ct = 8'h00;
    for (int i = 0; i < 26; i++) begin
      if (vt[i].u != cu || vt[i].pat != cp || vt[i].t != ct) begin
        cu = vt[i].u; cp = vt[i].pat; ct = vt[i].t;
        load_img(cu, cp);
        start(cu, ct);
        wait_fin(cu);
        job_checks(cu);
      end
      check($sformatf("vec%0d u%0d a%0d", i, vt[i].u, vt[i].addr),
            32'(mem[vt[i].u][vt[i].addr]), 32'(vt[i].exp));
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("border order %0d", i),
            ord[2][i], exp_ord[i]);

    // Stall at address 7; threshold change after start is ignored.
    load_img(1, 2);
    start(1, 8'd3);
    @(posedge clk);
    #1;
    thr[1] = 8'hFF;
    n = 0;
    while (!(req[1] && ga[1] == 7) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall reach", ga[1], 7);
    rdy[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall req %0d", k), 32'(req[1]), 0);
      check($sformatf("stall addr %0d", k), ga[1], 7);
      @(posedge clk);
      #1;
    end
    rdy[1] = 1'b1;
    wait_fin(1);
    job_checks(1);
    check_b("stall");

    // Reset mid-job at address 9, then a full rerun.
    start(1, 8'd3);
    n = 0;
    while (!(req[1] && ga[1] == 9) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort reach", ga[1], 9);
    rst_n[1] = 1'b0;
    #1;
    check("abort ctl", {29'd0, req[1], val[1], fin[1]}, 32'd0);
    check("abort addr", ga[1] + la[1] + 32'(ldat[1]), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    n = 0;
    while (!req[1] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("restart req", 32'(req[1]), 1);
    check("restart addr", ga[1], 0);
    wait_fin(1);
    job_checks(1);
    check_b("rerun");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
